// File: rtl/laser_audio_mixer.sv
// laser_audio_mixer: time-multiplexed channel mixer with a one-pole
// low-pass bus and first-order sigma-delta DAC outputs.
module laser_audio_mixer #(
  parameter int NCH       = 4,
  parameter int IW        = 1,
  parameter int OW        = 16,
  parameter int CE_DIV    = 16,
  parameter int LPF_SHIFT = 5
) (
  input  logic              F14M,
  input  logic              reset_n,
  input  logic [NCH*IW-1:0] ch_in,
  input  logic [NCH*4-1:0]  ch_vol,
  input  logic [NCH-1:0]    ch_en,
  input  logic [NCH-1:0]    ch_lpf,
  input  logic [NCH*2-1:0]  ch_pan,
  input  logic              mute,
  input  logic              clip_clr,
  output logic              sample_strobe,
  output logic [OW-1:0]     mix_l,
  output logic [OW-1:0]     mix_r,
  output logic              dac_l,
  output logic              dac_r,
  output logic              clip
);
  localparam int AW = OW + $clog2(NCH) + 1;
  localparam int SW = AW + 1;
  localparam int KW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
  localparam int PW = IW + 4;
  localparam int SH = OW - IW - 4;
  localparam logic [OW-1:0] MAX = '1;

  typedef enum logic [1:0] {
    IDLE, ACCUM, FILTER, OUTPUT
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]     cnt;
  logic [KW-1:0]     k;
  logic [NCH*IW-1:0] s_in;
  logic [NCH*4-1:0]  s_vol;
  logic [NCH-1:0]    s_en;
  logic [NCH-1:0]    s_lpf;
  logic [NCH*2-1:0]  s_pan;
  logic              s_mute;
  logic [AW-1:0]     dl, dr, fl, fr;
  logic [OW-1:0]     y_l, y_r;
  logic [OW:0]       sd_l, sd_r;

  assign sample_strobe = (cnt == CW'(CE_DIV - 1));

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (sample_strobe) state_nx = ACCUM;
      ACCUM:   if (k == KW'(NCH - 1)) state_nx = FILTER;
      FILTER:  state_nx = OUTPUT;
      OUTPUT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  logic [IW-1:0] c_in;
  logic [3:0]    c_vol;
  logic [1:0]    c_pan;
  logic          c_en, c_lpf;
  logic [PW-1:0] prod;
  logic [AW-1:0] term;

  always_comb begin
    c_in  = s_in[k*IW +: IW];
    c_vol = s_vol[k*4 +: 4];
    c_pan = s_pan[k*2 +: 2];
    c_en  = s_en[k];
    c_lpf = s_lpf[k];
    prod  = PW'(c_in) * PW'(c_vol);
    term  = c_en ? (AW'(prod) << SH) : '0;
  end

  // filter input saturates to OW before the one-pole update
  logic              sat_fl, sat_fr, sat_ml, sat_mr, clip_set;
  logic [OW-1:0]     x_l, x_r, y_l_nx, y_r_nx, m_l, m_r;
  logic signed [OW:0] d_l, d_r;
  logic [SW-1:0]     s_l, s_r;

  always_comb begin
    sat_fl = |fl[AW-1:OW];
    sat_fr = |fr[AW-1:OW];
    x_l    = sat_fl ? MAX : fl[OW-1:0];
    x_r    = sat_fr ? MAX : fr[OW-1:0];
    d_l    = $signed({1'b0, x_l}) - $signed({1'b0, y_l});
    d_r    = $signed({1'b0, x_r}) - $signed({1'b0, y_r});
    y_l_nx = y_l + OW'(d_l >>> LPF_SHIFT);
    y_r_nx = y_r + OW'(d_r >>> LPF_SHIFT);
    s_l    = SW'(dl) + SW'(y_l_nx);
    s_r    = SW'(dr) + SW'(y_r_nx);
    sat_ml = |s_l[SW-1:OW];
    sat_mr = |s_r[SW-1:OW];
    m_l    = sat_ml ? MAX : s_l[OW-1:0];
    m_r    = sat_mr ? MAX : s_r[OW-1:0];
    clip_set = (state == FILTER) &&
               (sat_fl | sat_fr | sat_ml | sat_mr);
  end

  always_ff @(posedge F14M or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      k      <= '0;
      s_in   <= '0;
      s_vol  <= '0;
      s_en   <= '0;
      s_lpf  <= '0;
      s_pan  <= '0;
      s_mute <= 1'b0;
      dl     <= '0;
      dr     <= '0;
      fl     <= '0;
      fr     <= '0;
      y_l    <= '0;
      y_r    <= '0;
      mix_l  <= '0;
      mix_r  <= '0;
      clip   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= sample_strobe ? '0 : cnt + CW'(1);
      if (clip_set)
        clip <= 1'b1;
      else if (clip_clr)
        clip <= 1'b0;
      unique case (state)
        IDLE: if (sample_strobe) begin
          s_in   <= ch_in;
          s_vol  <= ch_vol;
          s_en   <= ch_en;
          s_lpf  <= ch_lpf;
          s_pan  <= ch_pan;
          s_mute <= mute;
          k      <= '0;
        end
        ACCUM: begin
          k <= k + KW'(1);
          if (c_pan[0] && !c_lpf) dl <= dl + term;
          if (c_pan[1] && !c_lpf) dr <= dr + term;
          if (c_pan[0] &&  c_lpf) fl <= fl + term;
          if (c_pan[1] &&  c_lpf) fr <= fr + term;
        end
        FILTER: begin
          y_l   <= y_l_nx;
          y_r   <= y_r_nx;
          mix_l <= s_mute ? '0 : m_l;
          mix_r <= s_mute ? '0 : m_r;
        end
        OUTPUT: begin
          dl <= '0;
          dr <= '0;
          fl <= '0;
          fr <= '0;
        end
        default: ;
      endcase
    end
  end

  // carry out of the OW-bit integrator is the 1-bit DAC stream
  always_ff @(posedge F14M or negedge reset_n) begin
    if (!reset_n) begin
      sd_l <= '0;
      sd_r <= '0;
    end else begin
      sd_l <= {1'b0, sd_l[OW-1:0]} + {1'b0, mix_l};
      sd_r <= {1'b0, sd_r[OW-1:0]} + {1'b0, mix_r};
    end
  end

  assign dac_l = sd_l[OW];
  assign dac_r = sd_r[OW];

endmodule

// File: tb/tb_laser_audio_mixer.sv
// tb_laser_audio_mixer: directed and random checks of the mixer against
// an integer reference model of the mixing rules.
module tb_laser_audio_mixer;
  localparam int NCH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  ch_in;
  logic [15:0] ch_vol;
  logic [3:0]  ch_en;
  logic [3:0]  ch_lpf;
  logic [7:0]  ch_pan;
  logic        mute;
  logic        clip_clr;
  logic        sample_strobe;
  logic [15:0] mix_l, mix_r;
  logic        dac_l, dac_r, clip;

  int n_chk = 0;
  int n_fail = 0;

  laser_audio_mixer #(
    .NCH(4), .IW(1), .OW(16), .CE_DIV(16), .LPF_SHIFT(5)
  ) dut (
    .F14M(clk), .reset_n(rst_n),
    .ch_in(ch_in), .ch_vol(ch_vol), .ch_en(ch_en),
    .ch_lpf(ch_lpf), .ch_pan(ch_pan),
    .mute(mute), .clip_clr(clip_clr),
    .sample_strobe(sample_strobe),
    .mix_l(mix_l), .mix_r(mix_r),
    .dac_l(dac_l), .dac_r(dac_r), .clip(clip)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model: plain integer sums per bus and side
  longint m_yl, m_yr, p_yl, p_yr, p_ml, p_mr, e_ml, e_mr;
  bit     p_clip, e_clip, c_set;
  int     m_cnt, m_cd;

  task automatic model_reset();
    m_yl = 0; m_yr = 0; p_yl = 0; p_yr = 0;
    p_ml = 0; p_mr = 0; e_ml = 0; e_mr = 0;
    p_clip = 0; e_clip = 0; m_cnt = 0; m_cd = 0;
  endtask

  task automatic model_scan();
    longint d[2], f[2], y[2], m[2];
    longint x, s, t;
    bit c;
    c = 0;
    d[0] = 0; d[1] = 0; f[0] = 0; f[1] = 0;
    for (int ch = 0; ch < NCH; ch++) begin
      if (ch_en[ch]) begin
        t = longint'(ch_in[ch]) * longint'(ch_vol[ch*4 +: 4]) * 2048;
        for (int sd = 0; sd < 2; sd++) begin
          if (ch_pan[2*ch+sd]) begin
            if (ch_lpf[ch]) f[sd] += t;
            else d[sd] += t;
          end
        end
      end
    end
    y[0] = m_yl; y[1] = m_yr;
    for (int sd = 0; sd < 2; sd++) begin
      x = (f[sd] > 65535) ? 65535 : f[sd];
      if (f[sd] > 65535) c = 1;
      y[sd] = y[sd] + ((x - y[sd]) >>> 5);
      s = d[sd] + y[sd];
      if (s > 65535) begin
        c = 1;
        s = 65535;
      end
      m[sd] = mute ? 0 : s;
    end
    p_yl = y[0]; p_yr = y[1];
    p_ml = m[0]; p_mr = m[1];
    p_clip = c;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        c_set = 0;
        if (m_cd > 0) begin
          m_cd--;
          if (m_cd == 0) begin
            m_yl = p_yl; m_yr = p_yr;
            e_ml = p_ml; e_mr = p_mr;
            c_set = p_clip;
          end
        end
        if (c_set) e_clip = 1;
        else if (clip_clr) e_clip = 0;
        if (m_cnt == 15) begin
          model_scan();
          m_cd = 5;
          m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_rng(input string tag, input longint obs,
                           input longint lo, input longint hi);
    n_chk++;
    assert (obs >= lo && obs <= hi) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_stb"}, sample_strobe, m_cnt == 15);
    check({tag, "_l"}, mix_l, e_ml);
    check({tag, "_r"}, mix_r, e_mr);
    check({tag, "_clip"}, clip, e_clip);
  endtask

  task automatic clear_inputs();
    ch_in = '0; ch_vol = '0; ch_en = '0;
    ch_lpf = '0; ch_pan = '0; mute = 0; clip_clr = 0;
  endtask

  task automatic set_ch(input int ch, input logic i, input logic [3:0] v,
                        input logic e, input logic l, input logic [1:0] p);
    ch_in[ch] = i;
    ch_vol[ch*4 +: 4] = v;
    ch_en[ch] = e;
    ch_lpf[ch] = l;
    ch_pan[ch*2 +: 2] = p;
  endtask

  task automatic wait_strobe();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (m_cnt != 15 && n < 40);
    check("wait_stb", sample_strobe, 1'b1);
  endtask

  task automatic run_tick();
    wait_strobe();
    repeat (6) @(negedge clk);
    check_all("tick");
  endtask

  initial begin
    longint prev;
    int nl, nr;
    clear_inputs();
    repeat (4) begin
      @(negedge clk);
      ch_in = 4'($urandom); ch_vol = 16'($urandom);
      ch_en = 4'($urandom); ch_lpf = 4'($urandom);
      ch_pan = 8'($urandom); mute = 1'($urandom);
      clip_clr = 1'($urandom);
      #1;
      check("rst_out", {sample_strobe, mix_l, mix_r, dac_l, dac_r, clip}, 0);
    end

    clear_inputs();
    set_ch(0, 1, 15, 1, 0, 2'b11);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i <= 40; i++) begin
      if (i > 0) @(negedge clk);
      check("first_stb", sample_strobe, (i % 16) == 15);
      check_all("boot");
      if (i == 20) check("mix_early", mix_l, 0);
      if (i == 21) begin
        check("mix6_l", mix_l, 30720);
        check("mix6_r", mix_r, 30720);
      end
    end

    nl = 0; nr = 0;
    repeat (65536) begin
      @(negedge clk);
      nl += int'(dac_l);
      nr += int'(dac_r);
    end
    check_rng("dac_l_density", nl, 30719, 30721);
    check_rng("dac_r_density", nr, 30719, 30721);

    clear_inputs();
    set_ch(1, 1, 8, 1, 0, 2'b01);
    wait_strobe();
    repeat (2) @(negedge clk);
    ch_in = '0;
    repeat (4) @(negedge clk);
    check("pan_l", mix_l, 16384);
    check("pan_r", mix_r, 0);
    check_all("pan");
    run_tick();
    check("pan_next_l", mix_l, 0);

    for (int ch = 0; ch < NCH; ch++) set_ch(ch, 1, 15, 1, 0, 2'b11);
    run_tick();
    check("clip_mix", mix_l, 65535);
    check("clip_set", clip, 1'b1);
    repeat (2) @(negedge clk);
    clip_clr = 1;
    @(negedge clk);
    clip_clr = 0;
    check("clip_clr", clip, 1'b0);
    wait_strobe();
    repeat (5) @(negedge clk);
    clip_clr = 1;
    @(negedge clk);
    clip_clr = 0;
    check("clip_set_wins", clip, 1'b1);
    check_all("clip");
    clear_inputs();
    set_ch(0, 1, 15, 1, 0, 2'b11);
    run_tick();
    @(negedge clk);
    clip_clr = 1;
    @(negedge clk);
    clip_clr = 0;
    check("clip_clr2", clip, 1'b0);
    run_tick();
    check("clip_stays0", clip, 1'b0);

    clear_inputs();
    set_ch(0, 1, 15, 1, 1, 2'b11);
    run_tick();
    check("lpf_1", mix_l, 960);
    run_tick();
    check("lpf_2", mix_l, 1890);
    check("lpf_2r", mix_r, 1890);
    prev = 1890;
    repeat (8) begin
      run_tick();
      check("lpf_rise", mix_l > prev, 1'b1);
      prev = longint'(mix_l);
    end
    mute = 1;
    repeat (3) begin
      run_tick();
      check("mute", mix_l, 0);
    end
    mute = 0;
    run_tick();
    check("unmute_rise", mix_l > prev, 1'b1);
    prev = longint'(mix_l);
    repeat (330) begin
      run_tick();
      check("lpf_mono", mix_l >= prev, 1'b1);
      prev = longint'(mix_l);
    end
    check_rng("lpf_conv", longint'(mix_l), 30689, 30720);

    clear_inputs();
    set_ch(0, 1, 15, 1, 0, 2'b11);
    set_ch(1, 1, 8, 1, 0, 2'b11);
    wait_strobe();
    repeat (2) @(negedge clk);
    rst_n = 0;
    #1;
    check("rst_mid", {sample_strobe, mix_l, mix_r, dac_l, dac_r, clip}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1;
    run_tick();
    check("post_rst_l", mix_l, 47104);
    check("post_rst_r", mix_r, 47104);

    repeat (30) begin
      ch_in = 4'($urandom); ch_vol = 16'($urandom);
      ch_en = 4'($urandom); ch_lpf = 4'($urandom);
      ch_pan = 8'($urandom);
      mute = ($urandom_range(0, 7) == 0);
      wait_strobe();
      repeat (3) @(negedge clk);
      ch_in = 4'($urandom);
      ch_vol = 16'($urandom);
      repeat (3) @(negedge clk);
      check_all("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
